// File: rtl/ped_scheduler.sv
// Pedestrian request scheduler: latches corner button presses, raises a crossing
// request to the traffic FSM, and enforces a serve watchdog plus a post-crossing cooldown.
module ped_scheduler #(
  parameter int CYCLES_PER_SEC = 16,
  parameter int COOLDOWN_SEC   = 2,
  parameter int SERVE_MAX_SEC  = 6
) (
  input  logic       clk,
  input  logic       i_maintenance_n,
  input  logic [3:0] i_ped_buttons,
  output logic       o_ped_req,
  input  logic       i_ped_ack,
  input  logic       i_ped_done,
  output logic [3:0] o_pending,
  output logic [3:0] o_served,
  output logic       o_busy,
  output logic       o_fault
);

  localparam int SERVE_LIM = SERVE_MAX_SEC * CYCLES_PER_SEC;
  localparam int COOL_LIM  = COOLDOWN_SEC * CYCLES_PER_SEC;
  localparam int MAX_LIM   = (SERVE_LIM > COOL_LIM) ? SERVE_LIM : COOL_LIM;
  localparam int CNT_W     = $clog2(MAX_LIM) + 1;

  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_LIM - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOL_LIM - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;
  localparam logic [1:0] ST_COOL  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [3:0]       btn_q;
  logic [3:0]       btn_edge;
  logic [3:0]       pending_nxt;
  logic [3:0]       served_nxt;
  logic             req_nxt;
  logic             fault_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign btn_edge = i_ped_buttons & ~btn_q;

  // A single counter is shared: it times the crossing in SERVE and the rest period in COOLDOWN.
  always_comb begin
    state_nxt   = state;
    pending_nxt = o_pending | btn_edge;
    served_nxt  = o_served;
    req_nxt     = o_ped_req;
    fault_nxt   = o_fault;
    cnt_nxt     = cnt;
    case (state)
      ST_IDLE: begin
        if (o_pending != 4'd0) begin
          state_nxt = ST_REQ;
          req_nxt   = 1'b1;
        end
      end
      ST_REQ: begin
        if (i_ped_ack) begin
          served_nxt  = o_pending | btn_edge;
          pending_nxt = 4'd0;
          req_nxt     = 1'b0;
          state_nxt   = ST_SERVE;
          cnt_nxt     = '0;
        end
      end
      ST_SERVE: begin
        // Done wins over a watchdog expiry landing in the same cycle.
        if (i_ped_done) begin
          state_nxt = ST_COOL;
          cnt_nxt   = '0;
        end else if (cnt == SERVE_LAST) begin
          fault_nxt = 1'b1;
          state_nxt = ST_COOL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_COOL: begin
        if (cnt == COOL_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        req_nxt   = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // btn_q still tracks the buttons during reset so a held button never looks like a press.
  always_ff @(posedge clk) begin
    btn_q <= i_ped_buttons;
    if (!i_maintenance_n) begin
      state     <= ST_IDLE;
      o_pending <= 4'd0;
      o_served  <= 4'd0;
      o_ped_req <= 1'b0;
      o_busy    <= 1'b0;
      o_fault   <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      o_pending <= pending_nxt;
      o_served  <= served_nxt;
      o_ped_req <= req_nxt;
      o_busy    <= (state_nxt != ST_IDLE);
      o_fault   <= fault_nxt;
      cnt       <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ped_scheduler.sv
// Testbench for ped_scheduler: directed vector table, hand-written timing sequences,
// and a randomized run checked against a timestamp-based reference model.
module tb_ped_scheduler;

  localparam int CPS       = 16;
  localparam int COOL_SEC  = 2;
  localparam int SERVE_SEC = 6;
  localparam int SERVE_LIM = SERVE_SEC * CPS;
  localparam int COOL_LIM  = COOL_SEC * CPS;

  logic       clk;
  logic       maint_n;
  logic [3:0] buttons;
  logic       ped_req;
  logic       ped_ack;
  logic       ped_done;
  logic [3:0] pending;
  logic [3:0] served;
  logic       busy;
  logic       fault;

  int n_compared;
  int n_mismatched;

  ped_scheduler #(
    .CYCLES_PER_SEC(CPS),
    .COOLDOWN_SEC(COOL_SEC),
    .SERVE_MAX_SEC(SERVE_SEC)
  ) dut (
    .clk(clk),
    .i_maintenance_n(maint_n),
    .i_ped_buttons(buttons),
    .o_ped_req(ped_req),
    .i_ped_ack(ped_ack),
    .i_ped_done(ped_done),
    .o_pending(pending),
    .o_served(served),
    .o_busy(busy),
    .o_fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phases with start timestamps instead of counters.
  typedef enum {PH_IDLE, PH_WAITING, PH_CROSSING, PH_RESTING} phase_t;
  phase_t     ref_phase;
  logic [3:0] ref_pending;
  logic [3:0] ref_served;
  logic [3:0] ref_prev;
  logic       ref_req;
  logic       ref_busy;
  logic       ref_fault;
  int         now;
  int         serve_start;
  int         rest_start;

  task automatic model_step(input logic rst_n, input logic [3:0] btn,
                            input logic ack, input logic done);
    logic [3:0] rise;
    now++;
    if (!rst_n) begin
      ref_phase   = PH_IDLE;
      ref_pending = 4'd0;
      ref_served  = 4'd0;
      ref_req     = 1'b0;
      ref_fault   = 1'b0;
      ref_prev    = btn;
    end else begin
      rise     = btn & ~ref_prev;
      ref_prev = btn;
      case (ref_phase)
        PH_IDLE: begin
          if (ref_pending != 4'd0) begin
            ref_phase = PH_WAITING;
            ref_req   = 1'b1;
          end
          ref_pending = ref_pending | rise;
        end
        PH_WAITING: begin
          if (ack) begin
            ref_served  = ref_pending | rise;
            ref_pending = 4'd0;
            ref_req     = 1'b0;
            ref_phase   = PH_CROSSING;
            serve_start = now;
          end else begin
            ref_pending = ref_pending | rise;
          end
        end
        PH_CROSSING: begin
          ref_pending = ref_pending | rise;
          if (done) begin
            ref_phase  = PH_RESTING;
            rest_start = now;
          end else if (now - serve_start >= SERVE_LIM) begin
            ref_fault  = 1'b1;
            ref_phase  = PH_RESTING;
            rest_start = now;
          end
        end
        default: begin
          ref_pending = ref_pending | rise;
          if (now - rest_start >= COOL_LIM) ref_phase = PH_IDLE;
        end
      endcase
    end
    ref_busy = (ref_phase != PH_IDLE);
  endtask

  task automatic applyStimulus(input logic rst_n, input logic [3:0] btn,
                               input logic ack, input logic done);
    maint_n  = rst_n;
    buttons  = btn;
    ped_ack  = ack;
    ped_done = done;
    @(posedge clk);
    model_step(rst_n, btn, ack, done);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] actual,
                             input logic [3:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic check_all(input string name, input logic [3:0] e_pend, input logic e_req,
                           input logic [3:0] e_srv, input logic e_busy, input logic e_fault);
    checkOutput({name, ".pending"}, pending, e_pend);
    checkOutput({name, ".ped_req"}, {3'b000, ped_req}, {3'b000, e_req});
    checkOutput({name, ".served"}, served, e_srv);
    checkOutput({name, ".busy"}, {3'b000, busy}, {3'b000, e_busy});
    checkOutput({name, ".fault"}, {3'b000, fault}, {3'b000, e_fault});
  endtask

  typedef struct {
    logic       rst_n;
    logic [3:0] btn;
    logic       ack;
    logic       done;
    logic [3:0] pend;
    logic       req;
    logic [3:0] srv;
    logic       busy;
    logic       fault;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [3:0] rb;
    n_compared   = 0;
    n_mismatched = 0;
    now          = 0;
    serve_start  = 0;
    rest_start   = 0;
    ref_phase    = PH_IDLE;
    ref_pending  = 4'd0;
    ref_served   = 4'd0;
    ref_prev     = 4'd0;
    ref_req      = 1'b0;
    ref_busy     = 1'b0;
    ref_fault    = 1'b0;
    maint_n      = 1'b0;
    buttons      = 4'd0;
    ped_ack      = 1'b0;
    ped_done     = 1'b0;

    //              rst   btn     ack   done  pend    req   srv     busy  fault
    vecs[0] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 4'b1101, 1'b0, 1'b0, 4'b1100, 1'b0, 4'b0001, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 4'b1101, 1'b0, 1'b1, 4'b1100, 1'b0, 4'b0001, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b1100, 1'b0, 4'b0001, 1'b1, 1'b0};

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].btn, vecs[i].ack, vecs[i].done);
      check_all($sformatf("vec%0d", i), vecs[i].pend, vecs[i].req, vecs[i].srv,
                vecs[i].busy, vecs[i].fault);
    end

    // Cooldown: done was at vec6, vec7 was its first cycle.
    for (int i = 2; i <= 31; i++) begin
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
      checkOutput($sformatf("cool%0d.ped_req", i), {3'b000, ped_req}, 4'b0000);
      checkOutput($sformatf("cool%0d.busy", i), {3'b000, busy}, 4'b0001);
    end
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    check_all("cool_end", 4'b1100, 1'b0, 4'b0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    check_all("req_after_cool", 4'b1100, 1'b1, 4'b0001, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    check_all("ack_1100", 4'b0000, 1'b0, 4'b1100, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);

    // Press in the same cycle as the ack is folded into served.
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0011, 1'b1, 1'b0);
    check_all("ack_with_press", 4'b0000, 1'b0, 4'b0011, 1'b1, 1'b0);

    // Watchdog expiry, then fault stays set through a later crossing.
    for (int i = 1; i <= 95; i++) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    checkOutput("wd_before.fault", {3'b000, fault}, 4'b0000);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    check_all("wd_expire", 4'b0000, 1'b0, 4'b0011, 1'b1, 1'b1);
    for (int i = 1; i <= 31; i++) applyStimulus(1'b1, 4'b0000, 1'b0, (i == 3));
    applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0);
    check_all("wd_rest_end", 4'b0100, 1'b0, 4'b0011, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0100, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
    check_all("fault_sticky", 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1);

    // Done landing on the watchdog's last cycle is a normal finish.
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1000, 1'b1, 1'b0);
    for (int i = 1; i <= 95; i++) applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b1);
    check_all("done_at_expiry", 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
    checkOutput("after_expiry.fault", {3'b000, fault}, 4'b0000);

    // Buttons held through reset must not request until released and pressed again.
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    check_all("held_thru_reset", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0);
    check_all("repress", 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0);
    check_all("repress_req", 4'b0010, 1'b1, 4'b0000, 1'b1, 1'b0);

    // Reset while requesting aborts everything.
    applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0);
    check_all("reset_in_req", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0);
    check_all("post_reset_idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Randomized run against the reference model.
    rb = 4'd0;
    for (int i = 0; i < 2500; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) rb[b] = ~rb[b];
      end
      applyStimulus((i == 0) ? 1'b0 : ($urandom_range(0, 299) != 0), rb,
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
      check_all($sformatf("rand%0d", i), ref_pending, ref_req, ref_served, ref_busy, ref_fault);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/ped_scheduler.md
PED_SCHEDULER -- requirements
Module: ped_scheduler

Interface
REQ-001 Parameter CYCLES_PER_SEC, default 16, clock cycles per second.
REQ-002 Parameter COOLDOWN_SEC, default 2, minimum seconds between end of one crossing and the next request.
REQ-003 Parameter SERVE_MAX_SEC, default 6, watchdog limit on crossing duration.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 i_maintenance_n  input  1  synchronous, active-low reset.
REQ-006 i_ped_buttons  input  4  raw pedestrian button levels, one per corner, synchronous to clk.
REQ-007 o_ped_req  output  1  crossing request to the traffic FSM.
REQ-008 i_ped_ack  input  1  single-cycle pulse from the traffic FSM: crossing started.
REQ-009 i_ped_done  input  1  single-cycle pulse from the traffic FSM: crossing finished.
REQ-010 o_pending  output  4  latched, not-yet-served corner requests.
REQ-011 o_served  output  4  snapshot of the corners covered by the current or last crossing.
REQ-012 o_busy  output  1  high in REQ, SERVE or COOLDOWN.
REQ-013 o_fault  output  1  sticky watchdog fault flag.

Function
REQ-014 Register btn_q samples i_ped_buttons every cycle; edge[k] = i_ped_buttons[k] & ~btn_q[k].
REQ-015 On any edge[k], pending[k] SHALL set at that same clock edge, in all states, and hold until captured.
REQ-016 States: IDLE, REQ, SERVE, COOLDOWN; all outputs are registered.
REQ-017 IDLE: if pending != 0, go to REQ; o_ped_req SHALL be 1 from the next cycle (2 edges after the button is first sampled high).
REQ-018 REQ: hold o_ped_req=1 until i_ped_ack=1, with no timeout.
- On ack: o_served = pending | edge; clear those pending bits; go to SERVE; o_ped_req=0 from the next cycle.
REQ-019 SERVE: on i_ped_done, go to COOLDOWN and load the cooldown counter.
- Watchdog counts cycles in SERVE; on reaching SERVE_MAX_SEC*CYCLES_PER_SEC without done, set o_fault=1 and go to COOLDOWN.
REQ-020 COOLDOWN: remain exactly COOLDOWN_SEC*CYCLES_PER_SEC cycles, then go to IDLE.
- New presses latch into pending during COOLDOWN, but no request is issued until IDLE.
REQ-021 i_ped_ack outside REQ and i_ped_done outside SERVE SHALL be ignored; done in the same cycle as the watchdog expiry SHALL count as done (no fault).
REQ-022 Held buttons SHALL NOT re-trigger; a new request requires release then press.
REQ-023 Counters sized by $clog2 of the larger of the two limits, plus 1; no wrap-around permitted.
REQ-024 o_served holds its value until the next capture.

Reset
REQ-025 While i_maintenance_n=0 at a clock edge:
- state=IDLE; pending, o_served, o_ped_req, o_busy, o_fault and counters = 0.
- btn_q loads i_ped_buttons, so buttons held through reset create no request.
REQ-026 Reset mid-operation (REQ/SERVE/COOLDOWN) SHALL abort immediately with the same values; o_fault cleared.

Verification (CYCLES_PER_SEC=16, COOLDOWN_SEC=2, SERVE_MAX_SEC=6)
REQ-027 Press button 0 from IDLE.
- o_pending=0001 next cycle; o_ped_req=1 one cycle later.
- Ack pulse -> o_served=0001, o_pending=0000, o_ped_req=0.
REQ-028 In SERVE, press buttons 2 and 3.
- o_pending=1100.
- After done, o_ped_req stays 0 for 32 cycles (COOLDOWN), then rises on the second cycle after COOLDOWN ends.
- Ack -> o_served=1100.
REQ-029 Press button 1 in the same cycle as the ack for pending 0001 -> o_served=0011, o_pending=0000.
REQ-030 No done for 96 cycles in SERVE -> o_fault=1 and COOLDOWN entered; o_fault remains 1 through later crossings until reset.
REQ-031 Button held high through reset and after -> no o_pending/o_ped_req; release and re-press -> request issued.
REQ-032 Reset asserted during REQ with o_ped_req=1 -> next cycle all outputs 0, state IDLE.
